// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with a configurable access latency.
// Holds the pipeline via mem_stall while a load or store is in flight.
module dmem_responder #(
    parameter int WORD    = 64,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [WORD-1:0] ALUOut,
    input  logic [WORD-1:0] MemData,
    output logic [WORD-1:0] r_data,
    output logic            mem_stall,
    output logic            mem_done,
    output logic            mem_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_is_wr;
    logic [IW-1:0]   r_idx;
    logic [WORD-1:0] r_wdata;
    logic [WORD-1:0] r_mem [DEPTH];

    logic            w_req;
    logic            w_hi;
    logic            w_err;
    logic            w_accept;
    logic            w_commit;
    logic [IW-1:0]   w_idx;

    assign w_req    = MemRead | MemWrite;
    assign w_hi     = (ALUOut >> (3 + IW)) != '0;
    assign w_err    = (ALUOut[2:0] != 3'b000) | w_hi
                    | (MemRead & MemWrite);
    assign w_idx    = ALUOut[3 +: IW];
    assign w_accept = (r_state == S_IDLE) & w_req;
    assign w_commit = (r_state == S_WAIT) & (r_cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: errors skip WAIT, DONE always returns to IDLE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = w_err ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Stall is combinational so the request cycle itself holds the pipe
    always_comb begin
        mem_stall = w_accept | (r_state == S_WAIT);
    end

    // Request latch, latency counter, load data and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_wr  <= 1'b0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_data   <= '0;
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            mem_done <= w_commit | (w_accept & w_err);
            mem_err  <= w_accept & w_err;
            if (w_accept & ~w_err) begin
                r_is_wr <= MemWrite;
                r_idx   <= w_idx;
                r_wdata <= MemData;
                r_cnt   <= CW'(LATENCY - 1);
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_commit & ~r_is_wr) begin
                r_data <= r_mem[r_idx];
            end
        end
    end

    // Storage array: not reset, written only when a store commits
    always_ff @(posedge clk) begin
        if (!rst && w_commit && r_is_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule
